// File: rtl/silc_slope_meter_if.sv
// Bus bundle between the SILC slope meter and its controller / acquisition core.
interface silc_slope_meter_if #(
    parameter int ADC_W = 12,
    parameter int RES_W = 16
) ();
    logic [1:0]       Mode;
    logic             Sel;
    logic [ADC_W-1:0] AdcSample;
    logic [5:0]       NumSlopes;
    logic [11:0]      TimeoutThr;
    logic             ReadAck;
    logic [RES_W-1:0] Result;
    logic [2:0]       ErrorCode;
    logic             Ready;
    logic             Busy;

    modport master (
        output Mode, Sel, AdcSample, NumSlopes, TimeoutThr, ReadAck,
        input  Result, ErrorCode, Ready, Busy
    );

    modport slave (
        input  Mode, Sel, AdcSample, NumSlopes, TimeoutThr, ReadAck,
        output Result, ErrorCode, Ready, Busy
    );
endinterface

// File: rtl/silc_slope_meter.sv
// SILC slope meter: measures descending slopes of the discharge sawtooth,
// accumulates their length over a commanded number of slopes, enforces a
// per-phase timeout and keeps the last good result for fast-mode readout.
module silc_slope_meter #(
    parameter int ADC_W     = 12,
    parameter int RES_W     = 16,
    parameter int DELTA_MIN = 1
) (
    input  logic              Clk,
    input  logic              En,
    silc_slope_meter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FALL,
        S_RISE,
        S_DONE
    } state_t;

    localparam logic [ADC_W:0] DMIN = DELTA_MIN[ADC_W:0];

    localparam logic [2:0] ERR_OK      = 3'd1;
    localparam logic [2:0] ERR_CONFIG  = 3'd2;
    localparam logic [2:0] ERR_NODATA  = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT = 3'd7;

    state_t           state, state_nxt;
    logic [ADC_W-1:0] prev, prev_nxt;
    logic [RES_W-1:0] acc, acc_nxt;
    logic [RES_W-1:0] slope_cnt, slope_cnt_nxt;
    logic [5:0]       slopes_done, slopes_done_nxt;
    logic [11:0]      phase_cnt, phase_cnt_nxt;
    logic [5:0]       num_slopes, num_slopes_nxt;
    logic [11:0]      thr, thr_nxt;
    logic [RES_W-1:0] result_q, result_nxt;
    logic [2:0]       err_q, err_nxt;
    logic             ready_q, ready_nxt;
    logic [RES_W-1:0] stored, stored_nxt;
    logic             stored_vld, stored_vld_nxt;

    logic [ADC_W:0]   diff_fall, diff_rise;
    logic             falling, rising;
    logic [RES_W:0]   acc_sum;
    logic [RES_W-1:0] acc_sat;
    logic [RES_W-1:0] slope_inc;
    logic [11:0]      phase_inc;
    logic             busy, abort, last_slope;
    logic             phase_tmo, slope_tmo;

    // Sample classification and saturating arithmetic helpers
    always_comb begin
        diff_fall  = {1'b0, prev} - {1'b0, bus.AdcSample};
        diff_rise  = {1'b0, bus.AdcSample} - {1'b0, prev};
        falling    = !diff_fall[ADC_W] && (diff_fall >= DMIN);
        rising     = !diff_rise[ADC_W] && (diff_rise >= DMIN);
        acc_sum    = {1'b0, acc} + {1'b0, slope_cnt};
        acc_sat    = acc_sum[RES_W] ? '1 : acc_sum[RES_W-1:0];
        slope_inc  = (slope_cnt == '1) ? slope_cnt : slope_cnt + 1'b1;
        phase_inc  = phase_cnt + 12'd1;
        busy       = (state == S_ARM) || (state == S_FALL) || (state == S_RISE);
        abort      = !bus.Sel || (bus.Mode == 2'b00);
        last_slope = (slopes_done + 6'd1) == num_slopes;
        phase_tmo  = (thr != '0) && (phase_inc >= thr);
        slope_tmo  = (thr != '0) && (slope_inc >= RES_W'(thr));
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt       = state;
        prev_nxt        = busy ? bus.AdcSample : prev;
        acc_nxt         = acc;
        slope_cnt_nxt   = slope_cnt;
        slopes_done_nxt = slopes_done;
        phase_cnt_nxt   = phase_cnt;
        num_slopes_nxt  = num_slopes;
        thr_nxt         = thr;
        result_nxt      = result_q;
        err_nxt         = err_q;
        ready_nxt       = ready_q;
        stored_nxt      = stored;
        stored_vld_nxt  = stored_vld;

        case (state)
            S_IDLE: begin
                ready_nxt = 1'b0;
                if (bus.Sel) begin
                    case (bus.Mode)
                        2'b10: begin
                            if (bus.NumSlopes != '0) begin
                                state_nxt       = S_ARM;
                                num_slopes_nxt  = bus.NumSlopes;
                                thr_nxt         = bus.TimeoutThr;
                                prev_nxt        = bus.AdcSample;
                                acc_nxt         = '0;
                                slope_cnt_nxt   = '0;
                                slopes_done_nxt = '0;
                                phase_cnt_nxt   = '0;
                            end else begin
                                state_nxt  = S_DONE;
                                result_nxt = '0;
                                err_nxt    = ERR_CONFIG;
                            end
                        end
                        2'b11: begin
                            state_nxt  = S_DONE;
                            result_nxt = '0;
                            err_nxt    = ERR_CONFIG;
                        end
                        2'b01: begin
                            state_nxt  = S_DONE;
                            result_nxt = stored_vld ? stored : '0;
                            err_nxt    = stored_vld ? ERR_OK : ERR_NODATA;
                        end
                        default: state_nxt = S_IDLE;
                    endcase
                end
            end
            S_ARM, S_RISE: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (falling) begin
                    state_nxt     = S_FALL;
                    slope_cnt_nxt = {{(RES_W-1){1'b0}}, 1'b1};
                    phase_cnt_nxt = '0;
                end else if (phase_tmo) begin
                    state_nxt  = S_DONE;
                    result_nxt = acc;
                    err_nxt    = ERR_TIMEOUT;
                end else begin
                    phase_cnt_nxt = phase_inc;
                end
            end
            S_FALL: begin
                // Completion is checked before timeout so a terminating rise wins
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (rising) begin
                    acc_nxt         = acc_sat;
                    slopes_done_nxt = slopes_done + 6'd1;
                    if (last_slope) begin
                        state_nxt      = S_DONE;
                        result_nxt     = acc_sat;
                        err_nxt        = ERR_OK;
                        stored_nxt     = acc_sat;
                        stored_vld_nxt = 1'b1;
                    end else begin
                        state_nxt     = S_RISE;
                        phase_cnt_nxt = '0;
                    end
                end else if (slope_tmo) begin
                    state_nxt  = S_DONE;
                    result_nxt = acc;
                    err_nxt    = ERR_TIMEOUT;
                end else begin
                    slope_cnt_nxt = slope_inc;
                end
            end
            S_DONE: begin
                ready_nxt = !bus.ReadAck;
                if (bus.ReadAck) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge Clk or negedge En) begin
        if (!En) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and output registers
    always_ff @(posedge Clk or negedge En) begin
        if (!En) begin
            prev        <= '0;
            acc         <= '0;
            slope_cnt   <= '0;
            slopes_done <= '0;
            phase_cnt   <= '0;
            num_slopes  <= '0;
            thr         <= '0;
            result_q    <= '0;
            err_q       <= '0;
            ready_q     <= 1'b0;
            stored      <= '0;
            stored_vld  <= 1'b0;
        end else begin
            prev        <= prev_nxt;
            acc         <= acc_nxt;
            slope_cnt   <= slope_cnt_nxt;
            slopes_done <= slopes_done_nxt;
            phase_cnt   <= phase_cnt_nxt;
            num_slopes  <= num_slopes_nxt;
            thr         <= thr_nxt;
            result_q    <= result_nxt;
            err_q       <= err_nxt;
            ready_q     <= ready_nxt;
            stored      <= stored_nxt;
            stored_vld  <= stored_vld_nxt;
        end
    end

    assign bus.Result    = result_q;
    assign bus.ErrorCode = err_q;
    assign bus.Ready     = ready_q;
    assign bus.Busy      = busy;

endmodule

// File: tb/tb_silc_slope_meter.sv
// Scoreboard bench for silc_slope_meter: stimulus pushes expected results,
// a monitor pops and compares on each rising Ready.
module tb_silc_slope_meter;

    typedef struct {
        string       name;
        logic [15:0] res;
        logic [2:0]  err;
    } exp_t;

    logic Clk;
    logic En;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    exp_t e;
    logic rdy_prev;

    silc_slope_meter_if #(.ADC_W(12), .RES_W(16)) bus ();

    silc_slope_meter #(.ADC_W(12), .RES_W(16), .DELTA_MIN(1)) dut (
        .Clk (Clk),
        .En  (En),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: compare against the scoreboard on every rising Ready
    initial rdy_prev = 1'b0;
    always @(negedge Clk) begin
        if (bus.Ready && !rdy_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got result %0d err %0d, expected no Ready",
                         bus.Result, bus.ErrorCode);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_result"}, 32'(bus.Result), 32'(e.res));
                check({e.name, "_err"}, 32'(bus.ErrorCode), 32'(e.err));
            end
        end
        rdy_prev = bus.Ready;
    end

    task automatic expect_result(input string nm, input logic [15:0] r, input logic [2:0] er);
        exp_t x;
        x.name = nm;
        x.res  = r;
        x.err  = er;
        exp_q.push_back(x);
    endtask

    task automatic step(input logic [11:0] s);
        bus.AdcSample = s;
        @(posedge Clk);
        #1;
    endtask

    task automatic start_slow(input logic [5:0] n, input logic [11:0] t, input logic [11:0] s);
        bus.Sel        = 1'b1;
        bus.Mode       = 2'b10;
        bus.NumSlopes  = n;
        bus.TimeoutThr = t;
        step(s);
    endtask

    task automatic wait_ready(input string nm, input int exp_lat);
        int n;
        n = 0;
        while (!bus.Ready && n < 20) begin
            @(posedge Clk);
            #1;
            n++;
        end
        if (!bus.Ready) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no Ready within %0d cycles, expected Ready", nm, n);
        end else if (exp_lat > 0) begin
            check({nm, "_latency"}, n, exp_lat);
        end
    endtask

    task automatic ack(input string nm);
        bus.Sel     = 1'b0;
        bus.Mode    = 2'b00;
        bus.ReadAck = 1'b1;
        @(posedge Clk);
        #1;
        bus.ReadAck = 1'b0;
        check({nm, "_ready_cleared"}, 32'(bus.Ready), 0);
        check({nm, "_busy_idle"}, 32'(bus.Busy), 0);
    endtask

    task automatic fast_req(input string nm, input logic [15:0] r, input logic [2:0] er);
        expect_result(nm, r, er);
        bus.Sel  = 1'b1;
        bus.Mode = 2'b01;
        @(posedge Clk);
        #1;
        bus.Sel  = 1'b0;
        bus.Mode = 2'b00;
        wait_ready(nm, 1);
        ack(nm);
    endtask

    task automatic sawtooth_slope(input int depth);
        for (int k = 1; k <= depth; k++) step(12'(100 - k));
        step(12'd100);
    endtask

    initial begin
        int rdy_seen;
        int guard;
        checks         = 0;
        errors         = 0;
        En             = 1'b0;
        bus.Sel        = 1'b0;
        bus.Mode       = 2'b00;
        bus.AdcSample  = 12'd100;
        bus.NumSlopes  = 6'd0;
        bus.TimeoutThr = 12'd0;
        bus.ReadAck    = 1'b0;
        #12;
        check("reset_result", 32'(bus.Result), 0);
        check("reset_err", 32'(bus.ErrorCode), 0);
        check("reset_ready", 32'(bus.Ready), 0);
        check("reset_busy", 32'(bus.Busy), 0);
        @(posedge Clk);
        #1;
        En = 1'b1;
        @(posedge Clk);
        #1;

        // Timeout in RISE after two 5-cycle slopes: 5+5=10, error 7
        expect_result("tmo", 16'd10, 3'd7);
        start_slow(6'd3, 12'd8, 12'd100);
        sawtooth_slope(5);
        sawtooth_slope(5);
        for (int k = 0; k < 7; k++) step(12'd100);
        check("tmo_busy_before_thr", 32'(bus.Busy), 1);
        step(12'd100);
        check("tmo_busy_at_thr", 32'(bus.Busy), 0);
        wait_ready("tmo", 1);
        ack("tmo");
        fast_req("fast_nodata", 16'd0, 3'd4);

        // Two 10-step slopes: 10+10=20, ok
        expect_result("saw2", 16'd20, 3'd1);
        start_slow(6'd2, 12'd0, 12'd100);
        sawtooth_slope(10);
        check("saw2_busy_mid", 32'(bus.Busy), 1);
        sawtooth_slope(10);
        check("saw2_ready_not_yet", 32'(bus.Ready), 0);
        wait_ready("saw2", 1);
        ack("saw2");
        fast_req("fast_stored20", 16'd20, 3'd1);

        // Flat samples inside a slope still count: 4
        expect_result("flat", 16'd4, 3'd1);
        start_slow(6'd1, 12'd0, 12'd100);
        step(12'd99);
        step(12'd99);
        step(12'd99);
        step(12'd98);
        step(12'd120);
        wait_ready("flat", 1);
        ack("flat");

        // Configuration errors
        expect_result("nslopes0", 16'd0, 3'd2);
        bus.Sel       = 1'b1;
        bus.Mode      = 2'b10;
        bus.NumSlopes = 6'd0;
        step(12'd100);
        wait_ready("nslopes0", 1);
        ack("nslopes0");
        expect_result("mode11", 16'd0, 3'd2);
        bus.Sel  = 1'b1;
        bus.Mode = 2'b11;
        step(12'd100);
        wait_ready("mode11", 1);
        ack("mode11");

        // Abort with Mode=00 mid-FALL: no Ready, stored result untouched
        start_slow(6'd2, 12'd0, 12'd100);
        step(12'd99);
        step(12'd98);
        step(12'd97);
        check("abort_busy_before", 32'(bus.Busy), 1);
        bus.Mode = 2'b00;
        step(12'd96);
        check("abort_busy_after", 32'(bus.Busy), 0);
        bus.Sel  = 1'b0;
        rdy_seen = 0;
        for (int k = 0; k < 6; k++) begin
            step(12'd95);
            if (bus.Ready) rdy_seen = 1;
        end
        check("abort_no_ready", rdy_seen, 0);
        fast_req("fast_after_abort", 16'd4, 3'd1);

        // Asynchronous reset mid-FALL
        start_slow(6'd2, 12'd0, 12'd100);
        step(12'd99);
        step(12'd98);
        check("rst_busy_before", 32'(bus.Busy), 1);
        #2;
        En = 1'b0;
        #1;
        check("rst_async_result", 32'(bus.Result), 0);
        check("rst_async_err", 32'(bus.ErrorCode), 0);
        check("rst_async_ready", 32'(bus.Ready), 0);
        check("rst_async_busy", 32'(bus.Busy), 0);
        bus.Sel  = 1'b0;
        bus.Mode = 2'b00;
        @(posedge Clk);
        #1;
        En = 1'b1;
        @(posedge Clk);
        #1;
        fast_req("fast_after_reset", 16'd0, 3'd4);

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge Clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
